mdu: RTL

Multi-cycle multiply/divide unit for the pipelined MIPS core, sitting in EX beside the single-cycle ALU. It adds `mult`/`multu`/`div`/`divu` with a fixed, parametrised latency, owns the architectural HI/LO registers, and serves `mthi`/`mtlo`/`mfhi`/`mflo`. The hazard unit stalls on `start | busy` when an MDU instruction sits in ID.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mdu.sv | 73 +++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings and FSM states shared by the multiply/divide unit and the core decoder.
package mdu_pkg;
   typedef enum logic [2:0] {
      MDU_NONE  = 3'b000,
      MDU_MULT  = 3'b001,
      MDU_MULTU = 3'b010,
      MDU_DIV   = 3'b011,
      MDU_DIVU  = 3'b100,
      MDU_MTHI  = 3'b101,
      MDU_MTLO  = 3'b110
   } mdu_op_e;
   typedef enum logic {IDLE, RUN} mdu_state_e;
endpackage

// File: rtl/mdu.sv
// mdu: fixed-latency multiply/divide unit owning HI/LO; the result is computed at issue
// and committed after MULT_CYCLES/DIV_CYCLES.
module mdu
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);
   mdu_state_e state, state_d;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] res_hi, res_lo, quo, rem;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0] da, db;
   logic dz, is_mul, is_div, sgn, go, done, idle_start;
   assign busy = state == RUN;
   // One extra bit keeps signed MIN / -1 representable, so its low half is MIN with remainder 0.
   always_comb begin
      is_mul     = op == MDU_MULT || op == MDU_MULTU;
      is_div     = op == MDU_DIV || op == MDU_DIVU;
      sgn        = op == MDU_MULT || op == MDU_DIV;
      idle_start = state == IDLE && start;
      go         = idle_start && (is_mul || is_div);
      done       = state == RUN && cnt == '0;
      state_d    = go ? RUN : done ? IDLE : state;
      prod       = {{WIDTH{sgn & rs_val[WIDTH-1]}}, rs_val} * {{WIDTH{sgn & rt_val[WIDTH-1]}}, rt_val};
      da         = {sgn & rs_val[WIDTH-1], rs_val};
      db         = rt_val == '0 ? (WIDTH+1)'(1) : {sgn & rt_val[WIDTH-1], rt_val};
      quo        = WIDTH'($signed(da) / $signed(db));
      rem        = WIDTH'($signed(da) % $signed(db));
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         res_hi <= '0;
         res_lo <= '0;
         dz     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_d;
         if (go) begin
            res_hi <= is_mul ? prod[2*WIDTH-1:WIDTH] : rem;
            res_lo <= is_mul ? prod[WIDTH-1:0] : quo;
            dz     <= is_div && rt_val == '0;
            cnt    <= is_mul ? MUL_LD : DIV_LD;
         end else if (busy && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (done && !dz) begin
            hi <= res_hi;
            lo <= res_lo;
         end
         if (idle_start && op == MDU_MTHI) hi <= rs_val;
         if (idle_start && op == MDU_MTLO) lo <= rs_val;
      end
   end
endmodule
